// File: rtl/counter.sv
// Free-running up counter with a terminal-count flag (End high while dout == MAX).
// Build option: define COUNTER_SATURATE_EN to hold at MAX instead of wrapping to 0.
module counter #(
  parameter int unsigned      WIDTH = 3,
  parameter logic [WIDTH-1:0] MAX   = WIDTH'((1 << WIDTH) - 1)
) (
  output logic [WIDTH-1:0] dout,
  input  logic             clk,
  input  logic             reset,
  output logic             End
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Out-of-range values (cnt_q > MAX) take the same path as the terminal count.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (cnt_q >= MAX) begin
`ifdef COUNTER_SATURATE_EN
      cnt_d = MAX;
`else
      cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign dout = cnt_q;
  assign End  = (cnt_q == MAX);

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default (3-bit, MAX 7) and 4-bit/MAX 9 instances,
// expected values queued at each clock edge and compared on the following falling edge.
module tb_counter;

  logic       clk;
  logic       rst;
  logic [2:0] dout;
  logic       end_f;
  logic [3:0] dout9;
  logic       end9;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          m  = 0;
  int          m9 = 0;
  int          end_cnt;

  typedef struct packed {
    logic [3:0] d;
    logic       e;
    logic [3:0] d9;
    logic       e9;
  } exp_t;

  exp_t q[$];

  counter dut (
    .dout  (dout),
    .clk   (clk),
    .reset (rst),
    .End   (end_f)
  );

  counter #(.WIDTH(4), .MAX(4'd9)) dut9 (
    .dout  (dout9),
    .clk   (clk),
    .reset (rst),
    .End   (end9)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int nxt(input int v, input int max);
`ifdef COUNTER_SATURATE_EN
    return (v >= max) ? max : v + 1;
`else
    return (v >= max) ? 0 : v + 1;
`endif
  endfunction

  function automatic exp_t model_now();
    exp_t x;
    x.d  = 4'(m);
    x.e  = (m == 7);
    x.d9 = 4'(m9);
    x.e9 = (m9 == 9);
    return x;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag);
    check({tag, "_dout"},  {1'b0, dout}, 4'(m));
    check({tag, "_end"},   {3'b0, end_f}, {3'b0, m == 7});
    check({tag, "_dout9"}, dout9, 4'(m9));
    check({tag, "_end9"},  {3'b0, end9}, {3'b0, m9 == 9});
  endtask

  task automatic compare_pop(input string tag);
    exp_t x;
    if (q.size() == 0) begin
      check({tag, "_queue"}, 4'd0, 4'd1);
      return;
    end
    x = q.pop_front();
    check({tag, "_dout"},  {1'b0, dout}, x.d);
    check({tag, "_end"},   {3'b0, end_f}, {3'b0, x.e});
    check({tag, "_dout9"}, dout9, x.d9);
    check({tag, "_end9"},  {3'b0, end9}, {3'b0, x.e9});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      m  = 0;
      m9 = 0;
    end else begin
      m  = nxt(m, 7);
      m9 = nxt(m9, 9);
    end
    q.push_back(model_now());
    @(negedge clk);
    compare_pop(tag);
  endtask

  // Reset released in the same time step as a rising edge: that edge must not count.
  task automatic tick_release(input string tag);
    @(posedge clk);
    m  = 0;
    m9 = 0;
    q.push_back(model_now());
    #0 rst = 1'b0;
    @(negedge clk);
    compare_pop(tag);
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    tick("reset_state");

    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick("count_first");

    rst = 1'b1;
    #2;
    m  = 0;
    m9 = 0;
    check_now("async_assert");
    tick("reset_held");
    tick("reset_held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick("count_after_reset");

    #3 rst = 1'b1;
    #1;
    m  = 0;
    m9 = 0;
    check_now("short_pulse");
    tick_release("release_on_edge");
    for (int i = 0; i < 3; i++) tick("count_after_pulse");

    for (int i = 0; i < 30; i++) tick("long_run");

    end_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick("end_window");
      if (end_f === 1'b1) end_cnt++;
    end
`ifdef COUNTER_SATURATE_EN
    check("end_duty", 4'(end_cnt), 4'd0);
    check("end_duty_sat", {3'b0, end_cnt == 16}, 4'd1);
`else
    check("end_duty", 4'(end_cnt), 4'd2);
`endif

    rst = 1'b1;
    #2;
    m  = 0;
    m9 = 0;
    check_now("final_reset");
    rst = 1'b0;
    tick("final_count");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
